debounce: RTL

DEBOUNCE -- requirements
Module: debounce

---
 rtl/debounce.sv | 89 ++++++++
 1 files changed

// File: rtl/debounce.sv
// rtl/debounce.sv - FSM debouncer: a level change is accepted after DEBOUNCE_CYCLES+1 stable samples.
// Optional: define DEBOUNCE_SYNC_EN to sample in through a two-flop synchronizer.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic debounced
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ZERO  = 2'b00,
    S_WAIT1 = 2'b01,
    S_ONE   = 2'b11,
    S_WAIT0 = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_in_s;
  logic             w_deb;
  logic             r_deb;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], in};
  end

  assign w_in_s = r_sync[1];
`else
  assign w_in_s = in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ZERO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter defaults to cleared, so every state change and both stable states reset it.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    case (r_state)
      S_ZERO: begin
        if (w_in_s) w_next = S_WAIT1;
      end
      S_WAIT1: begin
        if (!w_in_s)               w_next = S_ZERO;
        else if (r_cnt == CNT_LAST) w_next = S_ONE;
        else                        w_cnt_next = r_cnt + 1'b1;
      end
      S_ONE: begin
        if (!w_in_s) w_next = S_WAIT0;
      end
      S_WAIT0: begin
        if (w_in_s)                 w_next = S_ONE;
        else if (r_cnt == CNT_LAST) w_next = S_ZERO;
        else                        w_cnt_next = r_cnt + 1'b1;
      end
      default: w_next = S_ZERO;
    endcase
  end

  always_comb begin
    w_deb = (r_state == S_ONE) || (r_state == S_WAIT0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_deb <= 1'b0;
    else     r_deb <= w_deb;
  end

  assign debounced = r_deb;

endmodule
